// File: rtl/torv_mem_pkg.sv
// Shared types and defaults for the torv32 unified-memory arbiter.
// Owner tags route one-cycle-late RAM read data back to the port that issued the read.
package torv_mem_pkg;

  localparam int ADDR_W_DEFAULT     = 21;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_CNT_W       = 4;

  localparam logic [3:0] WMASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic logic is_read(input logic [3:0] wmask);
    return wmask == WMASK_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and single-port RAM signals of the arbiter.
// slave is the arbiter side; master is the core plus RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = torv_mem_pkg::ADDR_W_DEFAULT
);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic [31:0]       d_addr;
  logic [3:0]        d_wmask;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wmask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_valid, i_rdata,
    input  d_req, d_addr, d_wmask, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output ram_en, ram_addr, ram_wmask, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_valid, i_rdata,
    output d_req, d_addr, d_wmask, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  ram_en, ram_addr, ram_wmask, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles a request is denied; force is high once STARVE_MAX denials pile up.
// Zero-latency output from the registered count; clears on grant or on request withdrawal.
module arb_starve_cnt
  import torv_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic gnt,
  output logic force_gnt
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("arb_starve_cnt: STARVE_MAX must be in 1..15");
  end

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_gnt = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between fetch and data ports; data wins unless fetch is starved.
// Grants are combinational, read data returns one cycle later; a denied requester must hold and retry.
module mem_arbiter
  import torv_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  logic        i_gnt;
  logic        d_gnt;
  logic        fetch_forced;
  owner_t      owner_q;
  owner_t      owner_d;
  logic [31:0] i_hold;
  logic [31:0] d_hold;
  logic        i_valid;
  logic        d_valid;

  // Only the word-index bits of each address reach the RAM.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr, bus.d_addr};

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .resetn    (resetn),
    .req       (bus.i_req),
    .gnt       (i_gnt),
    .force_gnt (fetch_forced)
  );

  assign d_gnt = bus.d_req & ~(bus.i_req & fetch_forced);
  assign i_gnt = bus.i_req & ~d_gnt;

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.ram_en    = i_gnt | d_gnt;
  assign bus.ram_addr  = d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
  assign bus.ram_wmask = d_gnt ? bus.d_wmask : WMASK_NONE;
  assign bus.ram_wdata = bus.d_wdata;

  // Writes return nothing, so they leave no owner behind.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && is_read(bus.d_wmask)) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign i_valid = (owner_q == OWN_I);
  assign d_valid = (owner_q == OWN_D);

  // The core samples fetch data while stalled, so each port's last word must stay put.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (i_valid) begin
        i_hold <= bus.ram_rdata;
      end
      if (d_valid) begin
        d_hold <= bus.ram_rdata;
      end
    end
  end

  assign bus.i_valid = i_valid;
  assign bus.d_valid = d_valid;
  assign bus.i_rdata = i_valid ? bus.ram_rdata : i_hold;
  assign bus.d_rdata = d_valid ? bus.ram_rdata : d_hold;

  a_single_grant : assert property (@(posedge clk) disable iff (!resetn)
    !(i_gnt && d_gnt));

  a_fetch_never_writes : assert property (@(posedge clk) disable iff (!resetn)
    i_gnt |-> (bus.ram_wmask == WMASK_NONE));

  a_single_valid : assert property (@(posedge clk) disable iff (!resetn)
    !(i_valid && d_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;
  import torv_mem_pkg::*;

  localparam int AW   = 21;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus();

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'hA5C3_0F11;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
  endfunction

  // Environment RAM: synchronous, read-before-write.
  logic [31:0] ram_mem [int];
  int          rw;
  logic [31:0] rtmp;
  always @(posedge clk) begin
    if (bus.ram_en === 1'b1) begin
      rw = int'(bus.ram_addr);
      if (!ram_mem.exists(rw)) ram_mem[rw] = init_word(rw);
      rtmp = ram_mem[rw];
      bus.ram_rdata <= rtmp;
      for (int b = 0; b < 4; b++)
        if (bus.ram_wmask[b]) rtmp[8*b +: 8] = bus.ram_wdata[8*b +: 8];
      ram_mem[rw] = rtmp;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [int];
  typedef struct { int cyc; logic [31:0] dat; } exp_t;
  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] i_hold_exp = '0;
  logic [31:0] d_hold_exp = '0;
  int          denied_run = 0;
  logic        last_i_gnt = 1'b0;
  logic        last_d_gnt = 1'b0;

  function automatic logic [31:0] ref_rd(input int w);
    if (!ref_mem.exists(w)) ref_mem[w] = init_word(w);
    return ref_mem[w];
  endfunction

  task automatic ref_wr(input int w, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] t;
    t = ref_rd(w);
    for (int b = 0; b < 4; b++)
      if (m[b]) t[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = t;
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    ram_mem[w] = v;
    ref_mem[w] = v;
  endtask

  task automatic reset_model();
    iq.delete();
    dq.delete();
    i_hold_exp = '0;
    d_hold_exp = '0;
    denied_run = 0;
  endtask

  // Monitor: every cycle each port either delivers the queued word or holds its last one.
  exp_t mon_e;
  always @(negedge clk) begin
    if (iq.size() != 0 && iq[0].cyc == cyc) begin
      mon_e = iq.pop_front();
      chk("i_valid", 32'(bus.i_valid), 32'd1);
      chk("i_rdata", bus.i_rdata, mon_e.dat);
      i_hold_exp = mon_e.dat;
    end else begin
      chk("i_valid_idle", 32'(bus.i_valid), 32'd0);
      chk("i_rdata_hold", bus.i_rdata, i_hold_exp);
    end
    if (dq.size() != 0 && dq[0].cyc == cyc) begin
      mon_e = dq.pop_front();
      chk("d_valid", 32'(bus.d_valid), 32'd1);
      chk("d_rdata", bus.d_rdata, mon_e.dat);
      d_hold_exp = mon_e.dat;
    end else begin
      chk("d_valid_idle", 32'(bus.d_valid), 32'd0);
      chk("d_rdata_hold", bus.d_rdata, d_hold_exp);
    end
  end

  // Evaluate this cycle's request at the falling edge: data wins unless fetch was
  // already turned away SMAX cycles in a row.
  task automatic eval();
    logic ed, ei;
    int   w;
    @(negedge clk);
    ed = bus.d_req && !(bus.i_req && denied_run >= SMAX);
    ei = bus.i_req && !ed;
    chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
    chk("i_gnt", 32'(bus.i_gnt), 32'(ei));
    chk("ram_en", 32'(bus.ram_en), 32'(ed | ei));
    if (ed) begin
      w = word_of(bus.d_addr);
      chk("ram_addr_d", 32'(bus.ram_addr), 32'(w));
      chk("ram_wmask_d", 32'(bus.ram_wmask), 32'(bus.d_wmask));
      chk("ram_wdata", bus.ram_wdata, bus.d_wdata);
      if (bus.d_wmask == 4'b0000) dq.push_back('{cyc: cyc + 1, dat: ref_rd(w)});
      else ref_wr(w, bus.d_wmask, bus.d_wdata);
    end else if (ei) begin
      w = word_of(bus.i_addr);
      chk("ram_addr_i", 32'(bus.ram_addr), 32'(w));
      chk("ram_wmask_i", 32'(bus.ram_wmask), 32'd0);
      iq.push_back('{cyc: cyc + 1, dat: ref_rd(w)});
    end else begin
      chk("ram_wmask_idle", 32'(bus.ram_wmask), 32'd0);
    end
    denied_run = (bus.i_req && !ei) ? denied_run + 1 : 0;
    last_i_gnt = ei;
    last_d_gnt = ed;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_addr  = da;
    bus.d_wmask = dm;
    bus.d_wdata = dw;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[22:2] = 21'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests asserted.
    resetn = 1'b0;
    set_req(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0200, 4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    chk("rst_i_valid", 32'(bus.i_valid), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    eval();
    chk("rel_first_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("rel_first_i_gnt", 32'(bus.i_gnt), 32'd0);
    next();
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval(); next();

    // Fetch only.
    preload(32'hC000, 32'h0000_0013);
    set_req(1'b1, 32'h0003_0000, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval();
    chk("fetch_gnt", 32'(bus.i_gnt), 32'd1);
    next();
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    #2;
    chk("fetch_valid", 32'(bus.i_valid), 32'd1);
    chk("fetch_rdata", bus.i_rdata, 32'h0000_0013);
    eval(); next();
    #2;
    chk("fetch_hold", bus.i_rdata, 32'h0000_0013);
    eval(); next();

    // Byte-lane store followed by a load of the same word.
    preload(32'h41, 32'h1122_3344);
    set_req(1'b0, 32'h0, 1'b1, 32'h0000_0104, 4'b0100, 32'h00AB_0000);
    eval(); next();
    set_req(1'b0, 32'h0, 1'b1, 32'h0000_0104, 4'b0000, 32'h0);
    #2;
    chk("store_no_dvalid", 32'(bus.d_valid), 32'd0);
    eval(); next();
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    #2;
    chk("load_dvalid", 32'(bus.d_valid), 32'd1);
    chk("load_rdata", bus.d_rdata, 32'h11AB_3344);
    eval(); next();

    // Contention: fetch wins one cycle in every SMAX+1.
    set_req(1'b1, 32'h0000_0800, 1'b1, 32'h0000_0900, 4'b0000, 32'h0);
    for (int k = 0; k < 15; k++) begin
      eval();
      chk("starve_pattern", 32'(bus.i_gnt), 32'(k % 5 == 4));
      next();
    end
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval(); next();

    // Async reset while a fetch read is in flight.
    set_req(1'b1, 32'h0003_0000, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval();
    #1;
    resetn = 1'b0;
    reset_model();
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    next();
    eval(); next();
    resetn = 1'b1;
    eval(); next();
    #2;
    chk("rst_mid_i_valid", 32'(bus.i_valid), 32'd0);
    chk("rst_mid_i_rdata", bus.i_rdata, 32'd0);

    // Reset with a partly built starvation count; count must restart from zero.
    set_req(1'b1, 32'h0000_0800, 1'b1, 32'h0000_0900, 4'b0000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      eval();
      if (k < 2) next();
    end
    #1;
    resetn = 1'b0;
    reset_model();
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    next();
    eval(); next();
    resetn = 1'b1;
    set_req(1'b1, 32'h0000_0800, 1'b1, 32'h0000_0900, 4'b0000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      eval();
      chk("post_rst_pattern", 32'(bus.i_gnt), 32'(k % 5 == 4));
      next();
    end
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval(); next();

    // Alternating data / fetch reads of distinct words.
    for (int k = 0; k < 8; k++) preload(32'h50 + k, 32'hC0DE_0000 + 32'(k));
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) set_req(1'b0, 32'h0, 1'b1, (32'h50 + 32'(k)) << 2, 4'b0000, 32'h0);
      else            set_req(1'b1, (32'h50 + 32'(k)) << 2, 1'b0, 32'h0, 4'b0000, 32'h0);
      eval(); next();
    end
    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    eval(); next();

    // Random traffic; a denied requester holds its request unchanged.
    for (int k = 0; k < 400; k++) begin
      if (!bus.i_req || last_i_gnt) begin
        bus.i_req  = ($urandom_range(0, 99) < 55);
        bus.i_addr = rand_addr();
      end
      if (!bus.d_req || last_d_gnt) begin
        bus.d_req   = ($urandom_range(0, 99) < 55);
        bus.d_addr  = rand_addr();
        bus.d_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
        bus.d_wdata = $urandom;
      end
      eval(); next();
    end

    set_req(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    repeat (3) begin
      eval(); next();
    end
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
